// File: rtl/capture_read_ctrl.sv
// Capture RAM read-back controller: sweeps every RAM address once wr_done is seen and
// streams the words out as fixed-length sop/eop packets, absorbing the RAM read latency.
module capture_read_ctrl #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int PKT_LEN    = 256,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rf_capture_start,
    input  logic              wr_done,
    output logic              ren,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              rd_busy,
    output logic              rd_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] PKT_MASK  = ADDR_W'(PKT_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] wcnt_q;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [PW:0]       cnt_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic [CW-1:0] inflight;
    logic [CW-1:0] used;
    logic          credit_ok;
    logic          ren_int;
    logic          push;
    logic          fifo_valid;
    logic          xfer;
    logic          last_xfer;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(vld_q[i]);
        end
    end

    // Credit counts words still in the RAM pipeline, so a full FIFO never loses a return.
    assign used       = inflight + CW'(cnt_q);
    assign credit_ok  = used < CW'(FIFO_DEPTH);
    assign ren_int    = (state_q == S_READ) && credit_ok;
    assign vld_d      = RD_LAT'({vld_q, ren_int});
    assign push       = vld_q[RD_LAT-1];
    assign fifo_valid = cnt_q != '0;
    assign xfer       = fifo_valid && out_ready;
    assign last_xfer  = xfer && (wcnt_q == LAST_ADDR);

    always_comb begin
        state_d = state_q;
        if (rf_capture_start) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (wr_done) state_d = S_READ;
                S_READ:  if (ren_int && (raddr_q == LAST_ADDR)) state_d = S_DRAIN;
                S_DRAIN: if (last_xfer) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            raddr_q <= '0;
            wcnt_q  <= '0;
            vld_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (rf_capture_start) begin
                raddr_q <= '0;
                wcnt_q  <= '0;
                vld_q   <= '0;
                wptr_q  <= '0;
                rptr_q  <= '0;
                cnt_q   <= '0;
            end else begin
                vld_q <= vld_d;
                if (ren_int) raddr_q <= raddr_q + 1'b1;
                if (push) wptr_q <= wptr_q + 1'b1;
                if (xfer) begin
                    rptr_q <= rptr_q + 1'b1;
                    wcnt_q <= wcnt_q + 1'b1;
                end
                case ({push, xfer})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= rdata;
    end

    assign ren       = ren_int;
    assign raddr     = raddr_q;
    assign out_valid = fifo_valid;
    assign out_data  = fifo_valid ? mem[rptr_q] : '0;
    assign out_sop   = fifo_valid && ((wcnt_q & PKT_MASK) == '0);
    assign out_eop   = fifo_valid && ((wcnt_q & PKT_MASK) == PKT_MASK);
    assign rd_busy   = (state_q == S_READ) || (state_q == S_DRAIN);
    assign rd_done   = state_q == S_DONE;

endmodule

// File: doc/capture_read_ctrl.md
Name: capture_read_ctrl

Overview:
- Read-side companion to the capture write-address generator in pktctrl.
- Once the capture RAM is full (`wr_done`), it reads every address 0..2^ADDR_W-1 in order and absorbs the RAM read latency.
- It delivers samples on a valid/ready stream framed into fixed-length packets (sop/eop) for the packet controller.
- It raises `rd_done` after the last word is accepted. `rf_capture_start` re-arms it.

Parameters:
- ADDR_W, 15, capture RAM address width; depth = 2^ADDR_W words.
- DATA_W, 16, sample word width.
- PKT_LEN, 256, words per packet; power of two, <= 2^ADDR_W.
- RD_LAT, 1, RAM read latency in cycles from `ren`/`raddr` to `rdata`; legal values 1 or 2.
- FIFO_DEPTH, 4, output buffer entries; power of two, >= RD_LAT+2.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- rf_capture_start  in  1  register pulse: abort and re-arm
- wr_done  in  1  level from write side: capture RAM full
- ren  out  1  RAM read enable
- raddr  out  ADDR_W  RAM read address
- rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after `ren`
- out_data  out  DATA_W  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_sop  out  1  first word of packet, qualified by `out_valid`
- out_eop  out  1  last word of packet, qualified by `out_valid`
- rd_busy  out  1  high in READ or DRAIN
- rd_done  out  1  sticky: all 2^ADDR_W words transferred

Behaviour:
- Reset values: `ren`=0, `raddr`=0, `out_valid`=0, `out_sop`=0, `out_eop`=0, `out_data`=0, `rd_busy`=0, `rd_done`=0. Reset puts the FSM in IDLE, empties the FIFO and clears the in-flight count.
- FSM has four states: IDLE, READ, DRAIN, DONE.
- IDLE -> READ when `wr_done`=1, `rd_done`=0 and `rf_capture_start`=0.
- Read issue:
  - In READ, `ren`=1 in a cycle iff (in-flight reads + FIFO occupancy) < FIFO_DEPTH. This credit rule guarantees no returned word is ever dropped under backpressure.
  - `raddr` is registered and advances by 1 after each issued read.
  - Issuing address 2^ADDR_W-1 moves the FSM to DRAIN, with no further `ren`. `raddr` wraps to 0.
- Read return:
  - An RD_LAT-deep valid pipeline tracks issued reads.
  - When a tracked read returns, `rdata` is pushed into the FIFO that cycle.
- Stream output:
  - The FIFO head drives `out_data`. `out_valid` = FIFO not empty.
  - A transfer occurs when `out_valid` && `out_ready`. Push and pop in the same cycle are allowed, including when the FIFO is full.
  - `out_data`, `out_sop` and `out_eop` hold stable while `out_valid`=1 && `out_ready`=0.
- Framing:
  - A word counter of ADDR_W bits counts accepted transfers.
  - `out_sop` = (count mod PKT_LEN == 0). `out_eop` = (count mod PKT_LEN == PKT_LEN-1).
  - If PKT_LEN=1, both flags are high on every word.
- Completion:
  - DRAIN -> DONE on the cycle the word with count 2^ADDR_W-1 is accepted.
  - `rd_done` goes to 1 on the next clock edge and stays high while in DONE.
  - In DONE, `wr_done` is ignored, so there is no re-read.
- `rf_capture_start` has priority in any state. On the next edge:
  - FSM -> IDLE; `raddr`=0; word counter=0.
  - FIFO flushed; in-flight reads discarded (pipeline valids cleared); `rd_done`=0; `ren`=0.
  - Stale `wr_done` in the same cycle does not start a read.
- `wr_done` deasserting mid READ/DRAIN is ignored; the transfer completes.
- `rd_busy` = 1 in READ and DRAIN only.
- Throughput: with `out_ready` held at 1, one word per cycle after an initial latency of RD_LAT+1 cycles from the first `ren` to the first `out_valid`.

Test Plan:
- Setup: ADDR_W=6, PKT_LEN=16, RD_LAT=1, RAM model returns `rdata`=addr.
- Basic read: pulse `wr_done`=1 with `out_ready`=1 -> 64 words with values 0..63 in order, no gaps after the first word, `out_valid` at the second cycle after the first `ren`. sop on words 0/16/32/48, eop on 15/31/47/63. `rd_done`=1 one cycle after word 63; `raddr` back to 0.
- Backpressure: `out_ready` random at 30% high -> no loss or duplicates, values 0..63 in order. `ren` never issued when in-flight+occupancy=4. Stalled outputs hold stable.
- RD_LAT=2: same as basic read with `out_ready` toggling every cycle -> data intact, 64 words.
- Abort: `rf_capture_start` pulse after 20 words accepted -> next cycle `out_valid`=0, `ren`=0, `raddr`=0, `rd_done`=0. Reasserting `wr_done` restarts from word 0 with sop.
- Re-arm gating: in DONE, hold `wr_done`=1 for 100 cycles -> no `ren`. After a `rf_capture_start` pulse with `wr_done` high again -> a full second pass.
- Reset mid-DRAIN: assert `rstn`=0 -> all outputs reach reset values asynchronously; after release, idle until `wr_done`.
